// File: rtl/pll_sup_if.sv
// pll_sup_if: signal bundle between the PLL lock supervisor and the PLL plus
// the downstream reset domain.
//   pll_locked   - PLL locked output, asynchronous to refclk
//   sw_relock    - single-cycle software re-lock request
//   pll_rst      - PLL reset input
//   sys_rst      - active-high downstream system reset
//   ready        - system released (RUN)
//   fail         - lock attempts exhausted (FAIL)
//   relock_count - saturating count of lock losses seen in RUN
// master: the supervisor. slave: the PLL / software side.
interface pll_sup_if;
   logic       pll_locked;
   logic       sw_relock;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] relock_count;

   modport master (
      input  pll_locked, sw_relock,
      output pll_rst, sys_rst, ready, fail, relock_count
   );

   modport slave (
      output pll_locked, sw_relock,
      input  pll_rst, sys_rst, ready, fail, relock_count
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the fabric PLL reset, waits for lock, holds
// the downstream reset until lock has been stable, and re-resets the PLL on
// lock loss.
// Ports:
//   refclk - free-running PLL reference clock (only clock)
//   rst    - synchronous active-high reset
//   bus    - pll_sup_if.master (pll_locked, sw_relock in; pll_rst, sys_rst,
//            ready, fail, relock_count out)
// Build option: define PLL_SUP_FAIL_LIMIT_EN to give up after MAX_RETRIES
// lock timeouts and park in FAIL; otherwise retries are unlimited and fail=0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RESET_PLL | pll_rst pulse of PLL_RST_CYCLES, system held in reset
// WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT for lk
// STABLE    | lk seen, must stay high for STABLE_CYCLES
// RUN       | system released, ready=1
// FAIL      | lock attempts exhausted (PLL_SUP_FAIL_LIMIT_EN only)
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT   = 1024,
   parameter int STABLE_CYCLES  = 256,
   parameter int MAX_RETRIES    = 4
) (
   input  logic      refclk,
   input  logic      rst,
   pll_sup_if.master bus
);

   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STABLE_CYCLES - 1);

   if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRIES < 1) begin : g_bad_param
      $error("pll_lock_supervisor: cycle parameters must be >= 1");
   end

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN
`ifdef PLL_SUP_FAIL_LIMIT_EN
      , S_FAIL
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sync_q, sync_d;
   logic [7:0]       relock_q, relock_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;
   logic             lk;

`ifdef PLL_SUP_FAIL_LIMIT_EN
   localparam int               RTY_W    = $clog2(MAX_RETRIES + 1);
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);
   logic [RTY_W-1:0] retries_q, retries_d;
`endif

   assign lk = sync_q[1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      relock_d = relock_q;
      sync_d   = {sync_q[0], bus.pll_locked};
`ifdef PLL_SUP_FAIL_LIMIT_EN
      retries_d = retries_q;
`endif

      // Timers count down from (N-1); terminal count 0 marks the Nth cycle.
      case (state_q)
         S_RESET_PLL: begin
            if (bus.sw_relock) begin
               cnt_d = RST_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = WAIT_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (bus.sw_relock) begin
               state_d = S_RESET_PLL;
               cnt_d   = RST_LOAD;
            end else if (lk) begin
               state_d = S_STABLE;
               cnt_d   = STB_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_RESET_PLL;
               cnt_d   = RST_LOAD;
`ifdef PLL_SUP_FAIL_LIMIT_EN
               retries_d = retries_q + RTY_W'(1);
               if (retries_q == RTY_LAST) begin
                  state_d = S_FAIL;
               end
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_STABLE: begin
            if (bus.sw_relock) begin
               state_d = S_RESET_PLL;
               cnt_d   = RST_LOAD;
            end else if (!lk) begin
               // A glitch restarts the lock wait but is not a failed attempt.
               state_d = S_WAIT_LOCK;
               cnt_d   = WAIT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_RUN;
`ifdef PLL_SUP_FAIL_LIMIT_EN
               retries_d = '0;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!lk || bus.sw_relock) begin
               state_d = S_RESET_PLL;
               cnt_d   = RST_LOAD;
            end
            // Only a real lock loss counts, even when software asks at the same time.
            if (!lk && relock_q != 8'hFF) begin
               relock_d = relock_q + 8'd1;
            end
         end
`ifdef PLL_SUP_FAIL_LIMIT_EN
         S_FAIL: begin
            if (bus.sw_relock) begin
               state_d   = S_RESET_PLL;
               cnt_d     = RST_LOAD;
               retries_d = '0;
            end
         end
`endif
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = RST_LOAD;
         end
      endcase

      // Outputs registered from the next state so they change on the deciding edge.
      pll_rst_d = (state_d == S_RESET_PLL);
      sys_rst_d = (state_d != S_RUN);
      ready_d   = (state_d == S_RUN);
      fail_d    = 1'b0;
`ifdef PLL_SUP_FAIL_LIMIT_EN
      pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      fail_d    = (state_d == S_FAIL);
`endif
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= RST_LOAD;
         sync_q    <= '0;
         relock_q  <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
`ifdef PLL_SUP_FAIL_LIMIT_EN
         retries_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync_q    <= sync_d;
         relock_q  <= relock_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
`ifdef PLL_SUP_FAIL_LIMIT_EN
         retries_q <= retries_d;
`endif
      end
   end

   assign bus.pll_rst      = pll_rst_q;
   assign bus.sys_rst      = sys_rst_q;
   assign bus.ready        = ready_q;
   assign bus.fail         = fail_q;
   assign bus.relock_count = relock_q;

endmodule
